prefetch_queue: RTL and testbench

Parametrised successor to the single-instruction fetcher. It keeps a byte ring buffer that is filled ahead of the consumer from a memory port of BUS_BYTES bytes per beat. It presents a 2-byte opcode and a 4-byte little-endian immediate at the head, and lets the consumer retire short (2 B) or long (6 B) instructions. On a redirect it keeps already-fetched bytes when the target lies inside the buffered window, instead of refetching.

---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_byte_ring.sv | 33 +++
 rtl/prefetch_queue.sv | 93 +++++++++
 tb/tb_prefetch_queue.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and instruction-size constants for the prefetch queue.
package fetch_pkg;
  localparam int ADDR_W        = 64;
  localparam int OPC_BYTES     = 2;
  localparam int IMM_BYTES     = 4;
  localparam int INS_MAX_BYTES = OPC_BYTES + IMM_BYTES;

  typedef logic [ADDR_W-1:0] addr_t;

  function automatic logic [2:0] retire_len(input logic take_long);
    return take_long ? 3'(INS_MAX_BYTES) : 3'(OPC_BYTES);
  endfunction
endpackage

// File: rtl/fetch_byte_ring.sv
// Byte ring storage: BUS_BYTES-wide write at a pointer, 6-byte read window at head.
module fetch_byte_ring #(
  parameter int BUF_BYTES = 16,
  parameter int BUS_BYTES = 1
) (
  input  logic                              clk,
  input  logic                              wr_en,
  input  logic [$clog2(BUF_BYTES)-1:0]      wr_ptr,
  input  logic [8*BUS_BYTES-1:0]            wr_data,
  input  logic [$clog2(BUF_BYTES)-1:0]      rd_ptr,
  output logic [8*fetch_pkg::INS_MAX_BYTES-1:0] rd_data
);
  import fetch_pkg::*;
  localparam int PTR_W = $clog2(BUF_BYTES);

  logic [7:0] mem [BUF_BYTES];

  // Contents need no reset; validity is tracked by the byte count in the parent.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < BUS_BYTES; i++) begin
        mem[wr_ptr + PTR_W'(i)] <= wr_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < INS_MAX_BYTES; i++) begin
      rd_data[8*i +: 8] = mem[rd_ptr + PTR_W'(i)];
    end
  end
endmodule

// File: rtl/prefetch_queue.sv
// Prefetching byte queue: fills ahead from memory, exposes opcode/immediate at head,
// and keeps buffered bytes on redirects that land inside the window.
module prefetch_queue #(
  parameter int                ADDR_W    = 64,
  parameter int                BUS_BYTES = 1,
  parameter int                BUF_BYTES = 16,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   redirect,
  input  logic [ADDR_W-1:0]      redirect_pc,
  output logic [ADDR_W-1:0]      fetch_addr,
  output logic                   m_req,
  input  logic                   m_valid,
  input  logic [8*BUS_BYTES-1:0] m_data,
  output logic [ADDR_W-1:0]      pc_out,
  output logic                   ins_valid,
  output logic                   imm_valid,
  output logic [15:0]            ins,
  output logic [31:0]            imm,
  input  logic                   take,
  input  logic                   take_long
);
  import fetch_pkg::*;
  localparam int PTR_W = $clog2(BUF_BYTES);
  localparam int CNT_W = $clog2(BUF_BYTES + 1);

  logic [ADDR_W-1:0]          head_pc, off;
  logic [PTR_W-1:0]           head_ptr, tail_ptr;
  logic [CNT_W-1:0]           count, wr_len, take_len;
  logic                       wr, retain, take_ok, ring_wr;
  logic [8*INS_MAX_BYTES-1:0] window;

  assign fetch_addr = head_pc + ADDR_W'(count);
  assign m_req      = ({1'b0, count} + (CNT_W+1)'(BUS_BYTES)) <= (CNT_W+1)'(BUF_BYTES);
  assign ins_valid  = count >= CNT_W'(OPC_BYTES);
  assign imm_valid  = count >= CNT_W'(INS_MAX_BYTES);
  assign pc_out     = head_pc;
  assign ins        = ins_valid ? window[8*OPC_BYTES-1:0] : '0;
  assign imm        = imm_valid ? window[8*INS_MAX_BYTES-1:8*OPC_BYTES] : '0;

  assign tail_ptr = head_ptr + count[PTR_W-1:0];
  assign wr       = m_req && m_valid;
  assign wr_len   = wr ? CNT_W'(BUS_BYTES) : '0;
  assign take_len = CNT_W'(retire_len(take_long));
  assign take_ok  = take && (take_long ? imm_valid : ins_valid);
  assign off      = redirect_pc - head_pc;
  assign retain   = off < ADDR_W'(count);
  // A retained redirect leaves the tail address unchanged, so the beat is still good.
  assign ring_wr  = wr && rst_n && !(redirect && !retain);

  fetch_byte_ring #(
    .BUF_BYTES (BUF_BYTES),
    .BUS_BYTES (BUS_BYTES)
  ) u_ring (
    .clk     (clk),
    .wr_en   (ring_wr),
    .wr_ptr  (tail_ptr),
    .wr_data (m_data),
    .rd_ptr  (head_ptr),
    .rd_data (window)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_pc  <= RESET_PC;
      head_ptr <= '0;
      count    <= '0;
    end else if (redirect) begin
      head_pc <= redirect_pc;
      if (retain) begin
        head_ptr <= head_ptr + off[PTR_W-1:0];
        count    <= count - off[CNT_W-1:0] + wr_len;
      end else begin
        count <= '0;
      end
    end else begin
      count <= count + wr_len - (take_ok ? take_len : '0);
      if (take_ok) begin
        head_ptr <= head_ptr + take_len[PTR_W-1:0];
        head_pc  <= head_pc + ADDR_W'(take_len);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && !redirect && take) begin
      assert (take_ok)
        else $warning("prefetch_queue: take ignored at pc %h, not enough bytes", head_pc);
    end
  end
endmodule

// File: tb/tb_prefetch_queue.sv
// Drives two queue instances (1- and 4-byte bus) against an address-level reference model.
module tb_prefetch_queue;
  import fetch_pkg::*;

  localparam addr_t RPC = 64'h100;

  logic  clk = 1'b0;
  always #5 clk = ~clk;

  logic  rst_n, redirect, take, take_long, m_valid;
  addr_t redirect_pc;

  addr_t       fa1, pc1, fa4, pc4;
  logic        mreq1, insv1, immv1, mreq4, insv4, immv4;
  logic [15:0] ins1, ins4;
  logic [31:0] imm1, imm4;
  logic [7:0]  m_data1;
  logic [31:0] m_data4;

  int checks = 0;
  int failures = 0;

  addr_t mpc [2];
  int    mcnt [2];

  function automatic logic [7:0] mb(input addr_t a);
    return a[7:0];
  endfunction

  assign m_data1 = mb(fa1);
  assign m_data4 = {mb(fa4 + 64'd3), mb(fa4 + 64'd2), mb(fa4 + 64'd1), mb(fa4)};

  prefetch_queue #(.ADDR_W(64), .BUS_BYTES(1), .BUF_BYTES(16), .RESET_PC(RPC)) u1 (
    .clk(clk), .rst_n(rst_n), .redirect(redirect), .redirect_pc(redirect_pc),
    .fetch_addr(fa1), .m_req(mreq1), .m_valid(m_valid), .m_data(m_data1),
    .pc_out(pc1), .ins_valid(insv1), .imm_valid(immv1), .ins(ins1), .imm(imm1),
    .take(take), .take_long(take_long));

  prefetch_queue #(.ADDR_W(64), .BUS_BYTES(4), .BUF_BYTES(16), .RESET_PC(RPC)) u4 (
    .clk(clk), .rst_n(rst_n), .redirect(redirect), .redirect_pc(redirect_pc),
    .fetch_addr(fa4), .m_req(mreq4), .m_valid(m_valid), .m_data(m_data4),
    .pc_out(pc4), .ins_valid(insv4), .imm_valid(immv4), .ins(ins4), .imm(imm4),
    .take(take), .take_long(take_long));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  // Next state from the behavioural rules: byte count and head address only.
  task automatic model_tick();
    for (int k = 0; k < 2; k++) begin
      int    bus;
      int    len;
      bit    wr;
      addr_t off;
      bus = (k == 0) ? 1 : 4;
      wr  = (mcnt[k] + bus <= 16) && m_valid;
      len = take_long ? 6 : 2;
      if (!rst_n) begin
        mpc[k]  = RPC;
        mcnt[k] = 0;
      end else if (redirect) begin
        off = redirect_pc - mpc[k];
        if (off < addr_t'(mcnt[k])) mcnt[k] = mcnt[k] - int'(off) + (wr ? bus : 0);
        else                        mcnt[k] = 0;
        mpc[k] = redirect_pc;
      end else begin
        mcnt[k] = mcnt[k] + (wr ? bus : 0);
        if (take && mcnt[k] - (wr ? bus : 0) >= len) begin
          mcnt[k] = mcnt[k] - len;
          mpc[k]  = mpc[k] + addr_t'(len);
        end
      end
    end
  endtask

  task automatic check_inst(input int k, input addr_t pc, input addr_t fa, input logic mreq,
                            input logic insv, input logic immv, input logic [15:0] ins,
                            input logic [31:0] imm);
    addr_t p;
    int    c;
    int    bus;
    p   = mpc[k];
    c   = mcnt[k];
    bus = (k == 0) ? 1 : 4;
    chk($sformatf("u%0d_pc", bus), pc, p);
    chk($sformatf("u%0d_fetch_addr", bus), fa, p + addr_t'(c));
    chk($sformatf("u%0d_m_req", bus), 64'(mreq), 64'(c + bus <= 16));
    chk($sformatf("u%0d_ins_valid", bus), 64'(insv), 64'(c >= 2));
    chk($sformatf("u%0d_imm_valid", bus), 64'(immv), 64'(c >= 6));
    chk($sformatf("u%0d_ins", bus), 64'(ins),
        (c >= 2) ? 64'({mb(p + 64'd1), mb(p)}) : 64'h0);
    chk($sformatf("u%0d_imm", bus), 64'(imm),
        (c >= 6) ? 64'({mb(p + 64'd5), mb(p + 64'd4), mb(p + 64'd3), mb(p + 64'd2)}) : 64'h0);
  endtask

  task automatic step();
    model_tick();
    @(posedge clk);
    #1;
    check_inst(0, pc1, fa1, mreq1, insv1, immv1, ins1, imm1);
    check_inst(1, pc4, fa4, mreq4, insv4, immv4, ins4, imm4);
  endtask

  initial begin
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0;
    take = 1'b0; take_long = 1'b0; m_valid = 1'b0;
    mpc[0] = '0; mpc[1] = '0; mcnt[0] = 0; mcnt[1] = 0;
    step();
    step();
    chk("reset_pc", pc1, RPC);
    chk("reset_m_req", 64'(mreq1), 64'h1);

    // Fill from reset with one byte per beat.
    rst_n = 1'b1; m_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      if (i == 1) chk("fill_ins", 64'(ins1), 64'h0100);
      if (i == 4) chk("fill_imm_not_yet", 64'(immv1), 64'h0);
      if (i == 5) chk("fill_imm", 64'(imm1), 64'h05040302);
    end
    chk("full_m_req", 64'(mreq1), 64'h0);
    chk("full_fetch_addr", fa1, 64'h110);

    // Long retire from a full buffer, then refill combined with a short retire.
    take = 1'b1; take_long = 1'b1;
    step();
    chk("take_long_pc", pc1, 64'h106);
    chk("take_long_count", fa1 - pc1, 64'd10);
    chk("take_long_ins", 64'(ins1), 64'h0706);
    take_long = 1'b0;
    step();
    take = 1'b0;
    chk("wr_take_count", fa1 - pc1, 64'd9);

    // Retain redirect inside a full window.
    rst_n = 1'b0; step(); rst_n = 1'b1;
    for (int i = 0; i < 16; i++) step();
    m_valid = 1'b0; redirect = 1'b1; redirect_pc = 64'h104;
    step();
    redirect = 1'b0;
    chk("retain_pc", pc1, 64'h104);
    chk("retain_count", fa1 - pc1, 64'd12);
    chk("retain_ins", 64'(ins1), 64'h0504);
    chk("retain_no_refetch", fa1, 64'h110);

    // Flush redirect with a beat arriving the same cycle.
    m_valid = 1'b1; redirect = 1'b1; redirect_pc = 64'h200;
    step();
    redirect = 1'b0;
    chk("flush_fa1", fa1, 64'h200);
    chk("flush_fa4", fa4, 64'h200);
    step();
    chk("flush_imm4_one_beat", 64'(immv4), 64'h0);
    step();
    chk("flush_imm4_two_beats", 64'(immv4), 64'h1);
    chk("flush_imm4_value", 64'(imm4), 64'h05040302);

    // Take with nothing buffered is ignored; stalled memory holds state.
    m_valid = 1'b0; redirect = 1'b1; redirect_pc = 64'h300;
    step();
    redirect = 1'b0; take = 1'b1; take_long = 1'b0;
    step();
    take = 1'b0;
    chk("empty_take_pc", pc1, 64'h300);
    m_valid = 1'b1; step(); step();
    m_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("stall_fa1", fa1, 64'h302);
    m_valid = 1'b1; step();
    rst_n = 1'b0; step(); rst_n = 1'b1;
    chk("midfill_reset_pc", pc1, RPC);
    chk("midfill_reset_fa", fa1, RPC);

    // Fetch across the top of the address space.
    redirect = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFE;
    step();
    redirect = 1'b0;
    step(); step();
    chk("wrap_fa1", fa1, 64'h0);
    chk("wrap_ins", 64'(ins1), 64'hFFFE);

    // Randomized traffic; takes are issued only when legal on both instances.
    for (int i = 0; i < 500; i++) begin
      int len;
      m_valid   = ($urandom % 4) != 0;
      rst_n     = ($urandom % 97) != 0;
      redirect  = ($urandom % 12) == 0;
      if ($urandom % 3 == 0) redirect_pc = {$urandom, $urandom};
      else                   redirect_pc = mpc[0] + addr_t'($urandom_range(0, 20));
      take_long = $urandom % 2;
      len       = take_long ? 6 : 2;
      take      = ($urandom % 2 == 1) && rst_n && !redirect &&
                  mcnt[0] >= len && mcnt[1] >= len;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
